// File: rtl/vip_stream_pkg.sv
// Shared constants for the 1-bit video stream source: FSM encoding,
// counter widths and the packed bitmap word width.
package vip_stream_pkg;

    localparam int CNT_W         = 11;
    localparam int BITMAP_WORD_W = 16;
    localparam int STATE_W       = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_VFRONT = 3'd4;

endpackage

// File: rtl/vip_bit_serializer.sv
// One-word holding buffer feeding a 16-bit shift register; pixels leave LSB
// first. An empty buffer at a load point yields a zero group and flags underrun.
module vip_bit_serializer
    import vip_stream_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     pix_en,
    input  logic                     load,
    input  logic [BITMAP_WORD_W-1:0] word_data,
    input  logic                     word_valid,
    output logic                     word_ready,
    input  logic                     underrun_clr,
    output logic                     underrun,
    output logic                     pix_bit
);

    logic [BITMAP_WORD_W-1:0] buf_q;
    logic [BITMAP_WORD_W-1:0] sreg_q;
    logic                     buf_full_q;
    logic                     xfer;

    assign word_ready = run && !buf_full_q;
    assign xfer       = word_valid && word_ready;

    // The first bit of a group bypasses the shift register so it lines up
    // with the first pixel cycle of that group.
    assign pix_bit = load ? (buf_full_q & buf_q[0]) : sreg_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            sreg_q     <= '0;
            buf_full_q <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (load) begin
                sreg_q <= buf_full_q ? (buf_q >> 1) : '0;
            end else if (pix_en) begin
                sreg_q <= sreg_q >> 1;
            end

            // A transfer is only possible while empty, so a fill in a load
            // cycle lands after the load has drained the buffer.
            if (xfer) begin
                buf_q      <= word_data;
                buf_full_q <= 1'b1;
            end else if (load) begin
                buf_full_q <= 1'b0;
            end

            if (underrun_clr) begin
                underrun <= 1'b0;
            end else if (load && !buf_full_q) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vip_bit_stream_gen.sv
// Source end of the 1-bit video stream: frame timing FSM plus a serializer
// that turns packed bitmap words into per-pixel bits.
module vip_bit_stream_gen
    import vip_stream_pkg::*;
#(
    parameter int IMG_HDISP = 1024,
    parameter int IMG_VDISP = 768,
    parameter int H_BLANK   = 16,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 4,
    parameter int V_FRONT   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [BITMAP_WORD_W-1:0] word_data,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic                     post_frame_vsync,
    output logic                     post_frame_href,
    output logic                     post_frame_clken,
    output logic                     post_img_Bit,
    output logic                     frame_done,
    output logic                     underrun,
    input  logic                     underrun_clr
);

    localparam int                LINE_LEN = IMG_HDISP + H_BLANK;
    localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0]  H_ACT    = CNT_W'(IMG_HDISP);

    state_t            state_q;
    state_t            state_d;
    state_t            after_frame;
    logic [CNT_W-1:0]  hcnt_q;
    logic [CNT_W-1:0]  vcnt_q;
    logic [CNT_W-1:0]  state_lines;
    logic              running;
    logic              line_end;
    logic              last_line;
    logic              frame_end;
    logic              pix_en;
    logic              load;
    logic              pix_bit;

    always_comb begin
        state_lines = CNT_W'(1);
        case (state_q)
            ST_VSYNC:  state_lines = CNT_W'(V_SYNC);
            ST_VBACK:  state_lines = CNT_W'(V_BACK);
            ST_ACTIVE: state_lines = CNT_W'(IMG_VDISP);
            ST_VFRONT: state_lines = CNT_W'(V_FRONT);
            default:   state_lines = CNT_W'(1);
        endcase
    end

    assign running     = (state_q != ST_IDLE);
    assign line_end    = running && (hcnt_q == H_LAST);
    assign last_line   = (vcnt_q == state_lines - CNT_W'(1));
    assign after_frame = enable ? ST_VSYNC : ST_IDLE;
    assign frame_end   = line_end && last_line &&
                         ((state_q == ST_VFRONT) || ((state_q == ST_ACTIVE) && (V_FRONT == 0)));

    // Zero-length porches are bypassed at the transition into them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable) state_d = ST_VSYNC;
            ST_VSYNC:  if (line_end && last_line) state_d = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
            ST_VBACK:  if (line_end && last_line) state_d = ST_ACTIVE;
            ST_ACTIVE: if (line_end && last_line) state_d = (V_FRONT > 0) ? ST_VFRONT : after_frame;
            ST_VFRONT: if (line_end && last_line) state_d = after_frame;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign pix_en = (state_q == ST_ACTIVE) && (hcnt_q < H_ACT);
    assign load   = pix_en && (hcnt_q[3:0] == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (!running) begin
                hcnt_q <= '0;
                vcnt_q <= '0;
            end else if (line_end) begin
                hcnt_q <= '0;
                vcnt_q <= last_line ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
            end
        end
    end

    vip_bit_serializer u_serializer (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (running),
        .pix_en       (pix_en),
        .load         (load),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .underrun_clr (underrun_clr),
        .underrun     (underrun),
        .pix_bit      (pix_bit)
    );

    // Output register stage: every stream signal lags the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            post_frame_vsync <= (state_q == ST_VSYNC);
            post_frame_href  <= pix_en;
            post_frame_clken <= pix_en;
            post_img_Bit     <= pix_en & pix_bit;
            frame_done       <= frame_end;
        end
    end

endmodule

// File: tb/tb_vip_bit_stream_gen.sv
// Directed bench for vip_bit_stream_gen on a 32x4 frame with short porches.
module tb_vip_bit_stream_gen;

    localparam int HD    = 32;
    localparam int VD    = 4;
    localparam int FRAME = 288;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic        post_img_Bit;
    logic        frame_done;
    logic        underrun;
    logic        underrun_clr;

    int n_cmp  = 0;
    int n_fail = 0;
    int feed_limit = 12;
    bit all_ones   = 1'b0;

    logic cap_pix [0:VD-1][0:HD-1];
    int   cap_href [0:7];
    int   cap_lines, cap_vs, cap_first_href, cap_fd_cnt, cap_fd_pos, cap_bad;

    always #5 clk = ~clk;

    vip_bit_stream_gen #(
        .IMG_HDISP (32),
        .IMG_VDISP (4),
        .H_BLANK   (4),
        .V_SYNC    (2),
        .V_BACK    (1),
        .V_FRONT   (1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .word_data        (word_data),
        .word_valid       (word_valid),
        .word_ready       (word_ready),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Bit     (post_img_Bit),
        .frame_done       (frame_done),
        .underrun         (underrun),
        .underrun_clr     (underrun_clr)
    );

    // Upstream word source: holds each word until it is accepted.
    initial begin : feeder
        int idx;
        bit went;
        idx = 0;
        went = 1'b0;
        word_valid = 1'b0;
        word_data = '0;
        forever begin
            @(negedge clk);
            if (went) idx++;
            if (idx < feed_limit) begin
                word_valid = 1'b1;
                word_data  = all_ones ? 16'hFFFF : (idx[0] ? 16'h8000 : 16'h0001);
            end else begin
                word_valid = 1'b0;
            end
            went = word_valid && word_ready;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded time budget");
        $fatal(1, "timeout");
    end

    // Records one frame starting at the sample where vsync is first seen high.
    task automatic capture_frame;
        int  ln, col;
        bit  prev;
        ln = -1; col = 0; prev = 1'b0;
        cap_vs = 0; cap_first_href = -1; cap_fd_cnt = 0; cap_fd_pos = -1; cap_bad = 0;
        for (int i = 0; i < 8; i++) cap_href[i] = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (post_frame_vsync) cap_vs++;
            if (post_frame_href) begin
                if (!prev) begin ln++; col = 0; end
                if (cap_first_href < 0) cap_first_href = c;
                if (ln >= 0 && ln < 8) cap_href[ln]++;
                if (ln >= 0 && ln < VD && col < HD) cap_pix[ln][col] = post_img_Bit;
                col++;
            end
            if (post_frame_clken !== post_frame_href ||
                (!post_frame_href && post_img_Bit !== 1'b0)) cap_bad++;
            if (frame_done) begin cap_fd_cnt++; cap_fd_pos = c; end
            prev = post_frame_href;
        end
        cap_lines = ln + 1;
    endtask

    task automatic test_reset;
        bit ok;
        rst_n = 1'b0; enable = 1'b1; underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, frame_done, underrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, frame_done, underrun});
        end
        n_cmp++;
        if (word_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_word_ready: got %b, want 0", word_ready);
        end
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (post_frame_vsync === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL vsync_start: got no vsync, want vsync within 5 cycles"); end
    endtask

    task automatic test_frame_timing;
        capture_frame();
        n_cmp++;
        if (cap_vs != 72) begin n_fail++; $display("FAIL vsync_len: got %0d, want 72", cap_vs); end
        n_cmp++;
        if (cap_first_href != 108) begin n_fail++; $display("FAIL first_href: got %0d, want 108", cap_first_href); end
        n_cmp++;
        if (cap_lines != VD) begin n_fail++; $display("FAIL line_count: got %0d, want %0d", cap_lines, VD); end
        for (int l = 0; l < VD; l++) begin
            n_cmp++;
            if (cap_href[l] != HD) begin n_fail++; $display("FAIL href_len line %0d: got %0d, want %0d", l, cap_href[l], HD); end
        end
        n_cmp++;
        if (cap_fd_cnt != 1 || cap_fd_pos != 287) begin
            n_fail++; $display("FAIL frame_done: got count %0d at %0d, want count 1 at 287", cap_fd_cnt, cap_fd_pos);
        end
        n_cmp++;
        if (cap_bad != 0) begin n_fail++; $display("FAIL clken_or_blank_bit: got %0d bad cycles, want 0", cap_bad); end
    endtask

    task automatic test_pixels;
        logic exp;
        for (int l = 0; l < VD; l++) begin
            for (int c = 0; c < HD; c++) begin
                exp = (c == 0 || c == HD - 1);
                n_cmp++;
                if (cap_pix[l][c] !== exp) begin
                    n_fail++; $display("FAIL pixel l%0d c%0d: got %b, want %b", l, c, cap_pix[l][c], exp);
                end
            end
        end
    endtask

    task automatic test_underrun;
        int ones2;
        ones2 = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++;
                if (post_frame_vsync !== 1'b1) begin n_fail++; $display("FAIL frame_b_vsync: got %b, want 1", post_frame_vsync); end
            end
            if (c >= 180 && c < 212 && post_img_Bit === 1'b1) ones2++;
            if (c == 179) begin
                n_cmp++;
                if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_pre: got %b, want 0", underrun); end
                underrun_clr = 1'b1;
            end
            if (c == 180) begin
                underrun_clr = 1'b0;
                n_cmp++;
                if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr_vs_set: got %b, want 0", underrun); end
            end
            if (c == 196) begin
                n_cmp++;
                if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b, want 1", underrun); end
            end
            if (c == 210) feed_limit = 1 << 30;
            if (c == 216 || c == 247) begin
                n_cmp++;
                if (post_img_Bit !== 1'b1) begin n_fail++; $display("FAIL line3_pixel at %0d: got %b, want 1", c, post_img_Bit); end
            end
            if (c == 249) begin
                n_cmp++;
                if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b, want 1", underrun); end
            end
            if (c == 250) underrun_clr = 1'b1;
            if (c == 251) begin
                underrun_clr = 1'b0;
                n_cmp++;
                if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: got %b, want 0", underrun); end
            end
            if (c == 287) begin
                n_cmp++;
                if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_b_done: got %b, want 1", frame_done); end
            end
        end
        n_cmp++;
        if (ones2 != 0) begin n_fail++; $display("FAIL underrun_line_zero: got %0d ones, want 0", ones2); end
    endtask

    task automatic test_enable_drop;
        int hrefs, idle_bad;
        hrefs = 0; idle_bad = 0;
        for (int c = 0; c < FRAME + 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++;
                if (post_frame_vsync !== 1'b1) begin n_fail++; $display("FAIL frame_c_vsync: got %b, want 1", post_frame_vsync); end
            end
            if (c == 150) enable = 1'b0;
            if (c < FRAME && post_frame_href === 1'b1) hrefs++;
            if (c == 287) begin
                n_cmp++;
                if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_c_done: got %b, want 1", frame_done); end
            end
            if (c >= FRAME && (post_frame_vsync || post_frame_href || word_ready || frame_done)) idle_bad++;
        end
        n_cmp++;
        if (hrefs != VD * HD) begin n_fail++; $display("FAIL frame_c_hrefs: got %0d, want %0d", hrefs, VD * HD); end
        n_cmp++;
        if (idle_bad != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d busy cycles, want 0", idle_bad); end
        n_cmp++;
        if (word_ready !== 1'b0 || post_frame_vsync !== 1'b0) begin
            n_fail++; $display("FAIL idle_state: got ready %b vsync %b, want 0 0", word_ready, post_frame_vsync);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int fd_seen;
        all_ones = 1'b1;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (post_frame_vsync === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL restart_vsync: got no vsync, want vsync within 5 cycles"); end
        repeat (154) @(negedge clk);
        n_cmp++;
        if (post_frame_href !== 1'b1) begin n_fail++; $display("FAIL mid_line1_href: got %b, want 1", post_frame_href); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, frame_done, word_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, want 000000",
                     {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, frame_done, word_ready});
        end
        fd_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done) fd_seen++;
        end
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (frame_done) fd_seen++;
            if (post_frame_vsync === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL fresh_vsync: got no vsync, want vsync within 5 cycles"); end
        capture_frame();
        fd_seen += cap_fd_cnt;
        n_cmp++;
        if (fd_seen != 1 || cap_fd_pos != 287) begin
            n_fail++; $display("FAIL fresh_frame_done: got count %0d at %0d, want count 1 at 287", fd_seen, cap_fd_pos);
        end
        n_cmp++;
        if (cap_vs != 72 || cap_first_href != 108) begin
            n_fail++; $display("FAIL fresh_timing: got vsync %0d href %0d, want 72 108", cap_vs, cap_first_href);
        end
    endtask

    task automatic test_all_ones;
        int ones, er_ones;
        logic e;
        ones = 0; er_ones = 0;
        @(negedge clk);
        n_cmp++;
        if (post_frame_vsync !== 1'b1) begin n_fail++; $display("FAIL ones_vsync: got %b, want 1", post_frame_vsync); end
        capture_frame();
        for (int l = 0; l < VD; l++)
            for (int c = 0; c < HD; c++)
                if (cap_pix[l][c] === 1'b1) ones++;
        for (int r = 1; r < VD - 1; r++) begin
            for (int c = 1; c < HD - 1; c++) begin
                e = 1'b1;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        e = e & cap_pix[r + dr][c + dc];
                if (e === 1'b1) er_ones++;
            end
        end
        n_cmp++;
        if (ones != VD * HD) begin n_fail++; $display("FAIL ones_pixels: got %0d, want %0d", ones, VD * HD); end
        n_cmp++;
        if (er_ones != (VD - 2) * (HD - 2)) begin
            n_fail++; $display("FAIL eroded_interior: got %0d, want %0d", er_ones, (VD - 2) * (HD - 2));
        end
    endtask

    initial begin : main
        test_reset();
        test_frame_timing();
        test_pixels();
        test_underrun();
        test_enable_drop();
        test_reset_mid_frame();
        test_all_ones();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vip_bit_stream_gen.md
Name: vip_bit_stream_gen

Overview:
- Source end of the 1-bit video stream interface (per_frame_vsync / href / clken / per_img_Bit) consumed by the binary morphology filters (erosion, dilation).
- Fetches packed 16-bit bitmap words over a valid/ready handshake and serialises them into pixel bits.
- Generates the matching frame timing: vsync, vertical porches, active lines, horizontal blanking.
- Used for replaying stored binary masks into the filter chain, and as the bench stimulus source for those filters.

Parameters:
- IMG_HDISP, 1024, active pixels per line; must be a multiple of 16.
- IMG_VDISP, 768, active lines per frame.
- H_BLANK, 16, blank cycles after each active line (>=2).
- V_SYNC, 4, lines with vsync high.
- V_BACK, 4, blank lines after vsync, before the first active line.
- V_FRONT, 4, blank lines after the last active line.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- enable  in  1  run request; sampled only in IDLE and at end of frame
- word_data  in  16  packed pixels, bit 0 = leftmost pixel
- word_valid  in  1  word_data valid
- word_ready  out  1  block accepts word_data this cycle
- post_frame_vsync  out  1  frame sync
- post_frame_href  out  1  active-pixel line window
- post_frame_clken  out  1  pixel enable; equals href (one pixel per clk)
- post_img_Bit  out  1  pixel value; 0 whenever href is low
- frame_done  out  1  one-cycle pulse at end of frame
- underrun  out  1  sticky: a pixel group was needed while no word was buffered
- underrun_clr  in  1  clears underrun

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset: every output is 0 and word_ready is 0. Buffer and shift register are emptied, counters cleared, FSM goes to IDLE. Reset mid-frame aborts the frame immediately; no frame_done is issued.
- Line length L = IMG_HDISP + H_BLANK cycles. Every vertical state counts in whole lines of L cycles.
- Column counter hcnt runs 0..L-1 and wraps. Line counter vcnt counts lines within the current state.
- FSM states:
  - IDLE: moves to VSYNC when enable=1.
  - VSYNC: V_SYNC lines with vsync=1.
  - VBACK: V_BACK lines.
  - ACTIVE: IMG_VDISP lines.
  - VFRONT: V_FRONT lines.
  - On the last cycle of VFRONT, frame_done=1. Next state is VSYNC if enable=1, otherwise IDLE.
  - A zero-length porch state (V_BACK or V_FRONT = 0) is skipped.
- In ACTIVE: href = clken = 1 for hcnt 0..IMG_HDISP-1, and 0 for the H_BLANK cycles.
- All outputs are registered. The first href cycle of a frame comes exactly V_SYNC*L + V_BACK*L + 1 cycles after the first cycle of VSYNC.
- Word path: one-word holding buffer plus a 16-bit shift register.
  - word_ready = !buf_full, and is also 0 in IDLE.
  - A transfer happens when word_valid && word_ready.
  - At each hcnt multiple of 16 inside the active window, the shift register loads from the buffer, and the buffer empties in the same cycle.
  - A transfer in that same cycle fills the buffer after the load, not before.
  - Pixel bits leave LSB first, one per href cycle.
- Underrun: if the buffer is empty at a load point, that 16-pixel group is output as all 0 and underrun is set. Timing continues unchanged; output never stalls.
- underrun_clr has priority over a coincident set, so underrun reads 0 the next cycle.
- Words offered outside a frame are buffered (one deep) only while not in IDLE. Upstream must hold word_valid/word_data until the transfer.
- enable deasserted mid-frame has no effect until the frame ends.

Decomposition:
- Shared package vip_stream_pkg:
  - FSM state encoding (IDLE, VSYNC, VBACK, ACTIVE, VFRONT).
  - Width constants for 11-bit hcnt/vcnt.
  - BITMAP_WORD_W = 16.
- One natural sub-module, vip_bit_serializer: holding buffer, shift register, ready/underrun logic. Timing FSM stays in the top.

Test Plan:
Bench parameters: IMG_HDISP=32, IMG_VDISP=4, H_BLANK=4, V_SYNC=2, V_BACK=1, V_FRONT=1, so L=36.
1. Reset with enable=1 and word_valid=1 → all outputs and word_ready are 0 during reset. After release, vsync is high for exactly 72 cycles, and the first href comes 108 cycles after vsync rises.
2. Feed words 0x0001, 0x8000, … continuously → the first pixel of line 0 is 1 and pixels 1..14 are 0. Pixel 31 of line 0 is 1. Each line has exactly 32 href cycles, and frame_done pulses once after 8 lines (288 cycles).
3. word_valid=0 for line 2 → that line outputs all 0 and underrun goes to 1 and stays there. Pulsing underrun_clr → underrun reads 0 the next cycle. A coincident set-and-clear also leaves 0.
4. Drop enable during ACTIVE → the frame completes all 4 lines, frame_done pulses, then the block goes to IDLE with word_ready=0 and vsync=0.
5. Assert rst_n low mid-line 1 → outputs go to 0 immediately. After release with enable=1 a fresh frame starts at VSYNC, and no frame_done is issued for the aborted frame.
6. Chain into the erosion filter with an all-ones bitmap → after the filter's pipeline warm-up, the filter output is 1 on interior pixels.
